// File: rtl/pipeline_load_reader_pkg.sv
// Shared load/store pipeline definitions: default widths and load formatting modes.
package pipeline_load_reader_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned REG_AW = 4;

  typedef enum logic [1:0] {
    MODE_WORD = 2'd0,
    MODE_LBZ  = 2'd1,
    MODE_HBZ  = 2'd2,
    MODE_LBS  = 2'd3
  } load_mode_e;

endpackage

// File: rtl/load_out_fifo.sv
// Synchronous FIFO with wrapping pointers; Depth must be a power of two.
module load_out_fifo #(
  parameter int unsigned Width = 20,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         pop_data,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);
  import pipeline_load_reader_pkg::*;

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(Depth));
  assign count    = count_q;
  assign do_pop   = pop && !empty;
  assign do_push  = push && !full;
  // Drive zero while empty so the head outputs read 0 out of reset.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pipeline_load_reader.sv
// Load pipeline: issues data-memory reads, formats results, writes the register bank and
// buffers results for a downstream consumer under credit-based flow control.
module pipeline_load_reader #(
  parameter int unsigned DATA_W    = pipeline_load_reader_pkg::DATA_W,
  parameter int unsigned ADDR_W    = pipeline_load_reader_pkg::ADDR_W,
  parameter int unsigned REG_AW    = pipeline_load_reader_pkg::REG_AW,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [1:0]        in_mode,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              busy
);
  import pipeline_load_reader_pkg::*;

  localparam int unsigned CntW = $clog2(OUT_DEPTH) + 1;

  logic              s1_valid_q, s2_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [REG_AW-1:0] s1_rd_q, s2_rd_q;
  load_mode_e        s1_mode_q, s2_mode_q;

  logic              rf_we_q;
  logic [REG_AW-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;

  logic [DATA_W-1:0] fmt_data;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [CntW:0]     credits_used;
  logic              accept;

  // Every load in S1/S2 already holds a buffer slot, so a push can never find it full.
  assign credits_used = {1'b0, fifo_count} + (CntW + 1)'(s1_valid_q) + (CntW + 1)'(s2_valid_q);
  assign in_ready     = rst_n && (credits_used < (CntW + 1)'(OUT_DEPTH));
  assign accept       = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_rd_q    <= '0;
      s1_mode_q  <= MODE_WORD;
      s2_valid_q <= 1'b0;
      s2_rd_q    <= '0;
      s2_mode_q  <= MODE_WORD;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_addr_q <= in_addr;
        s1_rd_q   <= in_rd;
        s1_mode_q <= load_mode_e'(in_mode);
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_rd_q   <= s1_rd_q;
        s2_mode_q <= s1_mode_q;
      end
    end
  end

  assign mem_re    = s1_valid_q;
  assign mem_raddr = s1_addr_q;

  always_comb begin
    fmt_data = '0;
    unique case (s2_mode_q)
      MODE_WORD: fmt_data = mem_rdata;
      MODE_LBZ:  fmt_data = DATA_W'(mem_rdata[7:0]);
      MODE_HBZ:  fmt_data = DATA_W'(mem_rdata[15:8]);
      MODE_LBS:  fmt_data = DATA_W'($signed(mem_rdata[7:0]));
      default:   fmt_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= s2_valid_q;
      if (s2_valid_q) begin
        rf_waddr_q <= s2_rd_q;
        rf_wdata_q <= fmt_data;
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  assign fifo_pop = out_valid && out_ready;

  load_out_fifo #(
    .Width(REG_AW + DATA_W),
    .Depth(OUT_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (s2_valid_q),
    .push_data({s2_rd_q, fmt_data}),
    .pop      (fifo_pop),
    .pop_data ({out_rd, out_data}),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign busy      = s1_valid_q || s2_valid_q || !fifo_empty;

  push_never_full_a: assert property (@(posedge clk) disable iff (!rst_n)
    s2_valid_q |-> !fifo_full);

endmodule

// File: tb/tb_pipeline_load_reader.sv
// Randomized self-checking bench for pipeline_load_reader with a behavioural memory and model.
module tb_pipeline_load_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_addr = '0;
  logic [3:0]  in_rd = '0;
  logic [1:0]  in_mode = '0;
  logic        mem_re;
  logic [7:0]  mem_raddr;
  logic [15:0] mem_rdata = '0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [3:0]  out_rd;
  logic        busy;

  logic [15:0] mem [256];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int outstanding = 0;
  int max_out = 0;
  logic [19:0] rf_obs[$];
  logic [19:0] out_obs[$];
  int          pop_cyc[$];

  pipeline_load_reader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_rd(in_rd), .in_mode(in_mode), .mem_re(mem_re), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_re) mem_rdata <= mem[mem_raddr];
  end

  // Passive recorder of register writes, consumer pops and occupancy.
  always @(negedge clk) begin
    if (rf_we) rf_obs.push_back({rf_waddr, rf_wdata});
    if (out_valid && out_ready) begin
      out_obs.push_back({out_rd, out_data});
      pop_cyc.push_back(cyc);
    end
    if (!rst_n) outstanding = 0;
    else begin
      if (in_valid && in_ready) outstanding++;
      if (out_valid && out_ready) outstanding--;
      if (outstanding > max_out) max_out = outstanding;
    end
  end

  // Reference formatting from the mode rules, using plain arithmetic.
  function automatic logic [15:0] fmt(input logic [15:0] d, input int mode);
    int lo;
    lo = int'(d) % 256;
    case (mode)
      0:       return d;
      1:       return 16'(lo);
      2:       return 16'(int'(d) / 256);
      default: return (lo >= 128) ? 16'(lo + 65280) : 16'(lo);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_addr = 8'h33;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({mem_re, rf_we, out_valid, in_ready, busy} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctrl cyc%0d: got %b expected 00000", i,
                 {mem_re, rf_we, out_valid, in_ready, busy});
      end
    end
    checks++;
    if ({mem_raddr, rf_waddr, rf_wdata, out_data, out_rd} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {mem_raddr, rf_waddr, rf_wdata, out_data});
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    mem[8'h10] = 16'hA5C3;
    in_valid = 1'b1; in_addr = 8'h10; in_rd = 4'd3; in_mode = 2'd0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL single_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({mem_re, mem_raddr} !== {1'b1, 8'h10}) begin
      errors++; $display("FAIL single_mem_re: got %b/%h expected 1/10", mem_re, mem_raddr);
    end
    tick();
    checks++;
    if ({mem_re, rf_we, out_valid} !== 3'b000) begin
      errors++; $display("FAIL single_early: got %b expected 000", {mem_re, rf_we, out_valid});
    end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd3, 16'hA5C3}) begin
      errors++; $display("FAIL single_rf: got %b/%h/%h expected 1/3/a5c3", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if ({out_valid, out_rd, out_data} !== {1'b1, 4'd3, 16'hA5C3}) begin
      errors++;
      $display("FAIL single_out: got %b/%h/%h expected 1/3/a5c3", out_valid, out_rd, out_data);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({rf_we, out_valid, busy} !== 3'b000) begin
      errors++; $display("FAIL single_drain: got %b expected 000", {rf_we, out_valid, busy});
    end
    out_ready = 1'b0;
  endtask

  task automatic test_modes();
    logic [15:0] data [4] = '{16'h80F0, 16'h80F0, 16'h80F0, 16'h0070};
    int          mode [4] = '{1, 2, 3, 3};
    logic [15:0] want [4] = '{16'h00F0, 16'h0080, 16'hFFF0, 16'h0070};
    logic [3:0]  rd;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd = 4'($urandom_range(0, 15));
      mem[8'h20 + i] = data[i];
      in_valid = 1'b1; in_addr = 8'(8'h20 + i); in_rd = rd; in_mode = 2'(mode[i]);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, rd, want[i]}) begin
        errors++;
        $display("FAIL mode%0d_rf: got %b/%h/%h expected 1/%h/%h", mode[i], rf_we, rf_waddr,
                 rf_wdata, rd, want[i]);
      end
      checks++;
      if ({out_valid, out_data} !== {1'b1, want[i]}) begin
        errors++;
        $display("FAIL mode%0d_out: got %b/%h expected 1/%h", mode[i], out_valid, out_data, want[i]);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [19:0] exp_q[$];
    out_ready = 1'b0;
    out_obs.delete();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_addr = 8'($urandom_range(0, 255));
      in_rd = 4'($urandom_range(0, 15));
      in_mode = 2'($urandom_range(0, 3));
      checks++;
      if (in_ready !== (i < 4)) begin
        errors++; $display("FAIL bp_ready req%0d: got %b expected %b", i, in_ready, i < 4);
      end
      if (i < 4) exp_q.push_back({in_rd, fmt(mem[in_addr], int'(in_mode))});
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b011) begin
      errors++; $display("FAIL bp_full: got %b expected 011", {in_ready, out_valid, busy});
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20 && out_obs.size() < 4; k++) tick();
    tick();
    checks++;
    if (out_obs.size() != 4) begin
      errors++; $display("FAIL bp_drain_count: got %0d expected 4", out_obs.size());
    end
    for (int i = 0; i < 4 && i < out_obs.size(); i++) begin
      checks++;
      if (out_obs[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_order[%0d]: got %h expected %h", i, out_obs[i], exp_q[i]);
      end
    end
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      errors++; $display("FAIL bp_recover: got %b expected 10", {in_ready, busy});
    end
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    logic [19:0] exp_q[$];
    int n_ready_bad = 0;
    int n_gap_bad = 0;
    out_ready = 1'b1;
    out_obs.delete(); rf_obs.delete(); pop_cyc.delete();
    max_out = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_addr = 8'((250 + i) % 256);
      in_rd = 4'($urandom_range(0, 15));
      in_mode = 2'($urandom_range(0, 3));
      if (in_ready !== 1'b1) n_ready_bad++;
      exp_q.push_back({in_rd, fmt(mem[in_addr], int'(in_mode))});
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 30 && out_obs.size() < 20; k++) tick();
    checks++;
    if (n_ready_bad != 0) begin
      errors++; $display("FAIL stream_ready: got %0d stalls expected 0", n_ready_bad);
    end
    checks++;
    if (out_obs.size() != 20 || rf_obs.size() != 20) begin
      errors++;
      $display("FAIL stream_count: got %0d/%0d expected 20/20", out_obs.size(), rf_obs.size());
    end
    for (int i = 0; i < 20 && i < out_obs.size() && i < rf_obs.size(); i++) begin
      checks++;
      if (out_obs[i] !== exp_q[i] || rf_obs[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stream_data[%0d]: got out %h rf %h expected %h", i, out_obs[i], rf_obs[i],
                 exp_q[i]);
      end
    end
    for (int i = 1; i < pop_cyc.size(); i++) if (pop_cyc[i] != pop_cyc[i-1] + 1) n_gap_bad++;
    checks++;
    if (n_gap_bad != 0) begin
      errors++; $display("FAIL stream_rate: got %0d gaps expected 0", n_gap_bad);
    end
    checks++;
    if (max_out > 4) begin
      errors++; $display("FAIL stream_occupancy: got %0d expected <= 4", max_out);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_midflight_reset();
    out_ready = 1'b1;
    out_obs.delete(); rf_obs.delete();
    in_valid = 1'b1; in_addr = 8'h44; in_rd = 4'd5; in_mode = 2'd0;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    checks++;
    if (rf_obs.size() != 0 || out_obs.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flush: got rf %0d out %0d busy %b expected 0 0 0", rf_obs.size(),
               out_obs.size(), busy);
    end
    test_single();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    test_reset();
    test_single();
    test_modes();
    test_backpressure();
    test_streaming();
    test_midflight_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
